// File: rtl/rk_pkg.sv
// Shared definitions for the Runge-Kutta step controller.
// Contents: the 3-bit controller state encoding, the RK4 stage index constants
// K1..K4 and the default time/counter widths.
package rk_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_ADVANCE = 3'd4,
    S_FIN     = 3'd5
  } rk_state_t;

  localparam logic [1:0] K1 = 2'd0;
  localparam logic [1:0] K2 = 2'd1;
  localparam logic [1:0] K3 = 2'd2;
  localparam logic [1:0] K4 = 2'd3;

  localparam int N_DEF  = 32;
  localparam int CW_DEF = 16;

endpackage

// File: rtl/comparator_nb.sv
// Unsigned n-bit magnitude comparator.
// Ports:
//   a, b      : unsigned operands
//   eq/lt/gt  : a == b, a < b, a > b (exactly one is high)
// Purely combinational.
module comparator_nb #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         eq,
  output logic         lt,
  output logic         gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/rk_step_sequencer.sv
// Step controller for the RK4 datapath. Walks t from t0 to t_end in steps of h
// and, for each step, issues the four stage requests k1..k4 one at a time,
// waiting for the datapath to report completion of each before the next.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   start              : run request (accepted only when idle)
//   t0, t_end, h       : start time, end time, step size (latched on start)
//   stage_done         : datapath completion pulse (honoured only in WAIT)
//   stage_go, stage    : one-cycle stage request and its index 0..3
//   t_out, step_cnt    : current time, completed step count
//   busy, done, err    : activity flag, end-of-run pulse, rejected-run flag
module rk_step_sequencer
  import rk_pkg::*;
#(
  parameter int n  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [n-1:0]  t0,
  input  logic [n-1:0]  t_end,
  input  logic [n-1:0]  h,
  input  logic          stage_done,
  output logic          stage_go,
  output logic [1:0]    stage,
  output logic [n-1:0]  t_out,
  output logic [CW-1:0] step_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  rk_state_t      state, state_nx;
  logic [n-1:0]   t_end_r;
  logic [n-1:0]   h_r;
  logic           cmp_eq, cmp_lt, cmp_gt;
  logic           reject;
  logic [n:0]     sum_adv;

  // Final step is clamped onto the end time, whether the sum wrapped past
  // n bits or simply overshot the limit.
  function automatic logic [n-1:0] clamp_time(input logic [n:0]   s,
                                              input logic [n-1:0] lim);
    if (s[n] || (s[n-1:0] > lim))
      return lim;
    return s[n-1:0];
  endfunction

  comparator_nb #(.n(n)) u_cmp (
    .a  (t_out),
    .b  (t_end_r),
    .eq (cmp_eq),
    .lt (cmp_lt),
    .gt (cmp_gt)
  );

  assign reject  = (h_r == '0) || cmp_gt;
  assign sum_adv = {1'b0, t_out} + {1'b0, h_r};

  assign stage_go = (state == S_ISSUE);
  assign done     = (state == S_FIN);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_CHECK;
      S_CHECK: begin
        if (reject || cmp_eq)
          state_nx = S_FIN;
        else if (cmp_lt)
          state_nx = S_ISSUE;
      end
      S_ISSUE:   state_nx = S_WAIT;
      S_WAIT:    if (stage_done) state_nx = (stage == K4) ? S_ADVANCE : S_ISSUE;
      S_ADVANCE: state_nx = S_CHECK;
      S_FIN:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_end_r  <= '0;
      h_r      <= '0;
      t_out    <= '0;
      step_cnt <= '0;
      stage    <= K1;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            t_end_r  <= t_end;
            h_r      <= h;
            t_out    <= t0;
            step_cnt <= '0;
            stage    <= K1;
            err      <= 1'b0;
          end
        end
        S_CHECK: begin
          if (reject)
            err <= 1'b1;
        end
        S_WAIT: begin
          if (stage_done)
            stage <= (stage == K4) ? K1 : stage + 2'd1;
        end
        S_ADVANCE: begin
          t_out    <= clamp_time(sum_adv, t_end_r);
          step_cnt <= step_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rk_step_sequencer.md
# rk_step_sequencer

Top-level step controller for the Runge-Kutta datapath. It walks the integration time `t` from `t0` to `t_end` in increments of `h`. For each step it issues the four RK4 stage requests (k1..k4) to the stage datapath, waiting for each stage to finish before issuing the next. The loop-termination decision uses one instance of the unsigned n-bit magnitude comparator (EQ/LT/GT outputs), which compares the running `t` against `t_end`.

## Interface
- `n`, 32, width of the time operands `t0`, `t_end`, `h` and `t_out` (unsigned)
- `CW`, 16, width of the step counter
- `clk` input 1 — single clock; all state updates on rising edge
- `reset` input 1 — synchronous, active-high; clears all state on the next rising edge
- `start` input 1 — request a run; sampled only in IDLE
- `t0` input n — start time, latched on accepted `start`
- `t_end` input n — end time, latched on accepted `start`
- `h` input n — step size, latched on accepted `start`
- `stage_done` input 1 — datapath completion pulse; honoured only in WAIT
- `stage_go` output 1 — one-cycle request to the datapath
- `stage` output 2 — stage index 0..3 (k1..k4), valid while `stage_go` is high and during WAIT
- `t_out` output n — current integration time
- `step_cnt` output CW — number of completed steps
- `busy` output 1 — high in every state except IDLE
- `done` output 1 — one-cycle pulse when a run ends
- `err` output 1 — high with `done` when the run is rejected; holds until the next accepted `start`
- Reset values: `stage_go`=0, `stage`=0, `t_out`=0, `step_cnt`=0, `busy`=0, `done`=0, `err`=0

## Operation
- States: IDLE, CHECK, ISSUE, WAIT, ADVANCE, FIN.
- IDLE:
  - `start`=1 latches `t0`/`t_end`/`h`, sets `t_out`←`t0`, clears `step_cnt`, `stage` and `err`, then goes to CHECK.
  - `start` is ignored in every other state.
- CHECK uses the comparator outputs on (`t_out`, `t_end`):
  - `h`==0 or GT → FIN with `err`←1.
  - EQ → FIN, a valid run with zero remaining steps.
  - LT → ISSUE.
- ISSUE: `stage_go`=1 for exactly one cycle, then WAIT.
- WAIT: hold until `stage_done`=1.
  - If `stage`<3: `stage`←`stage`+1, then ISSUE.
  - If `stage`==3: `stage`←0, then ADVANCE.
- ADVANCE:
  - Compute `t_out`+`h` at n+1 bits.
  - If the sum overflows n bits or exceeds `t_end`, then `t_out`←`t_end` (final step clamped); otherwise `t_out`←sum.
  - `step_cnt`←`step_cnt`+1, wrapping modulo 2^CW.
  - Go to CHECK.
- FIN: `done`=1 for one cycle, then IDLE. `t_out`, `step_cnt` and `err` hold their values in IDLE.
- A `stage_done` arriving in any state other than WAIT is dropped. This includes a pulse in the same cycle as `stage_go`.
- `reset` in any state, including mid-step, returns to IDLE with all outputs at their reset values. Any in-flight datapath stage is abandoned.

## Timing
- An accepted `start` at edge 0 puts the block in CHECK at edge 1.
  - Zero-step or error run: FIN at edge 2, so `done` is high during cycle 2–3. `busy` rises the cycle after `start`.
- Per step: the earliest path is 4 × (ISSUE + WAIT) + ADVANCE + CHECK = 10 cycles, when `stage_done` arrives the cycle after each `stage_go`.
- No latency bound on `stage_done`; WAIT has no timeout.
- `busy` falls in the cycle after FIN, together with the end of `done`.
- Comparator path is combinational into the CHECK decision: `t_out` register → comparator → next-state logic, inside one cycle.

## Structure
- Shared package/header `rk_pkg`: FSM state encodings (3-bit), stage index constants K1..K4 = 0..3, default `n`/`CW`.
- One sub-module: `comparator_nb` instantiated with `n` passed through, A=`t_out`, B=`t_end`. No other arithmetic is delegated; the adder stays local.
- The datapath itself is outside this block.

## Test plan
- t0=0, t_end=40, h=10; `stage_done` one cycle after each `stage_go` → 16 `stage_go` pulses with stage sequence 0,1,2,3 repeated; `done` with `step_cnt`=4, `t_out`=40, `err`=0; 10 cycles per step.
- t0=0, t_end=25, h=10 → 3 steps; `t_out` goes 10, 20, 25 (clamped); `step_cnt`=3.
- t0=0xFFFFFFF0, t_end=0xFFFFFFFF, h=0x20 → single step, overflow clamps `t_out`=0xFFFFFFFF; `step_cnt`=1.
- Error and degenerate runs:
  - t0=50, t_end=10 → `done` and `err`=1 two cycles after `start`, no `stage_go`.
  - h=0 → same error response.
  - t0=t_end=7 → `done`, `err`=0, `step_cnt`=0.
- Spurious `stage_done` in IDLE and in the ISSUE cycle → ignored; the stage does not advance until `stage_done` arrives in WAIT.
- Disturbance during a run:
  - `reset` asserted in WAIT of step 2 → next cycle IDLE, all outputs 0.
  - `start` pulsed mid-run → ignored; `t0` inputs are not re-latched.
